// File: rtl/adda_pkg.sv
// Shared definitions for the ADC capture path: sample width and capture FSM encoding.
package adda_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer; head is visible on rd_data whenever rd_valid is high.
module sample_fifo
    import adda_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [SAMPLE_W-1:0]    wr_data,
    input  logic                   rd_ready,
    output logic [SAMPLE_W-1:0]    rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         level_q, level_d;
    logic                full, pop, wr_ok;

    assign full     = (level_q == LEVEL_FULL);
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    assign wr_ok    = wr_valid && (!full || pop);
    assign drop     = wr_valid && full && !pop;
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Drives the ADC conversion clock, discards pipeline-latency samples after enable, buffers the rest.
module adc_capture
    import adda_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int PIPE_LAT   = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_25mhz,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [SAMPLE_W-1:0]         ad_data,
    output logic                        adclk,
    output logic [SAMPLE_W-1:0]         m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        overflow,
    input  logic                        clear_ovf,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(CLK_DIV / 2);
    localparam logic [FW-1:0] FLUSH_LAST = FW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    cap_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                adclk_q, adclk_d;
    logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                push_q, push_d;
    logic                overflow_q, overflow_d;
    logic                strobe;
    logic                fifo_drop;

    assign strobe = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                flush_cnt_d = '0;
                if (enable) begin
                    state_d = (PIPE_LAT == 0) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (strobe) begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
        end

        // Counter starts from 0 on the first active cycle so adclk opens with a full high phase.
        if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        adclk_d = (state_d != ST_IDLE) && (cnt_d < CNT_HALF);

        sample_d   = strobe ? ad_data : sample_q;
        push_d     = strobe && (state_q == ST_RUN) && enable;
        overflow_d = fifo_drop || (overflow_q && !clear_ovf);
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            adclk_q     <= 1'b0;
            flush_cnt_q <= '0;
            sample_q    <= '0;
            push_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adclk_q     <= adclk_d;
            flush_cnt_q <= flush_cnt_d;
            sample_q    <= sample_d;
            push_q      <= push_d;
            overflow_q  <= overflow_d;
        end
    end

    assign adclk    = adclk_q;
    assign overflow = overflow_q;

    sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_25mhz),
        .rst_n    (rst_n),
        .wr_valid (push_q),
        .wr_data  (sample_q),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .level    (level),
        .drop     (fifo_drop)
    );

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture at default parameters: adclk pattern, flush, overflow, drain, reset.
module tb_adc_capture;

    logic       clk_25mhz = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] ad_data;
    logic       adclk;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       overflow;
    logic       clear_ovf;
    logic [3:0] level;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ramp     = 0;
    logic adclk_prev = 1'b0;
    int   base;

    typedef struct {
        logic en;
        logic exp_adclk;
    } clk_vec_t;

    typedef struct {
        logic       rdy;
        logic [7:0] exp_data;
        int         exp_level;
    } drain_vec_t;

    clk_vec_t   clk_tbl   [12];
    drain_vec_t drain_tbl [10];

    adc_capture #(
        .CLK_DIV    (4),
        .PIPE_LAT   (5),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .enable    (enable),
        .ad_data   (ad_data),
        .adclk     (adclk),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .level     (level)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample 1 ns after the edge; present the next ramp value on each adclk rise.
    task automatic tick();
        @(posedge clk_25mhz);
        #1;
        if (adclk && !adclk_prev) begin
            ad_data = ramp[7:0];
            ramp++;
        end
        adclk_prev = adclk;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            clk_tbl[i].en        = 1'b1;
            clk_tbl[i].exp_adclk = ((i % 4) < 2);
        end
        drain_tbl[0] = '{1'b1, 8'd6,  8};
        drain_tbl[1] = '{1'b0, 8'd7,  7};
        drain_tbl[2] = '{1'b1, 8'd7,  7};
        drain_tbl[3] = '{1'b1, 8'd8,  6};
        drain_tbl[4] = '{1'b1, 8'd9,  5};
        drain_tbl[5] = '{1'b0, 8'd10, 4};
        drain_tbl[6] = '{1'b1, 8'd10, 4};
        drain_tbl[7] = '{1'b1, 8'd11, 3};
        drain_tbl[8] = '{1'b1, 8'd12, 2};
        drain_tbl[9] = '{1'b1, 8'd15, 1};

        rst_n = 1'b0; enable = 1'b0; ad_data = 8'h00; m_ready = 1'b0; clear_ovf = 1'b0;
        ticks(3);
        chk("rst_adclk",    adclk,    0);
        chk("rst_level",    level,    0);
        chk("rst_m_valid",  m_valid,  0);
        chk("rst_m_data",   m_data,   0);
        chk("rst_overflow", overflow, 0);

        // adclk 1,1,0,0 from the first enabled edge
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            enable = clk_tbl[i].en;
            tick();
            chk($sformatf("adclk_c%0d", i), adclk, clk_tbl[i].exp_adclk);
        end

        // five flushed strobes; sixth strobe (value 5) lands one edge after its push cycle
        ticks(12);
        tick();
        chk("flush_level_e24", level, 0);
        chk("flush_valid_e24", m_valid, 0);
        tick();
        chk("first_valid", m_valid, 1);
        chk("first_data",  m_data,  5);
        chk("first_level", level,   1);

        ticks(28);
        chk("fill_level_e53", level,    8);
        chk("fill_ovf_e53",   overflow, 0);
        ticks(4);
        chk("ovf_level",   level,    8);
        chk("ovf_set",     overflow, 1);
        chk("ovf_head",    m_data,   5);

        // drop and clear in the same cycle keeps overflow; clear alone then wins
        ticks(3);
        clear_ovf = 1'b1;
        tick();
        chk("ovf_set_and_clear", overflow, 1);
        tick();
        chk("ovf_clear", overflow, 0);
        clear_ovf = 1'b0;

        // push while full with a same-cycle pop
        ticks(2);
        m_ready = 1'b1;
        tick();
        chk("full_pop_level", level,    8);
        chk("full_pop_ovf",   overflow, 0);
        chk("full_pop_head",  m_data,   6);
        m_ready = 1'b0;
        enable  = 1'b0;
        tick();
        chk("idle_adclk", adclk, 0);
        chk("idle_keep_level", level, 8);
        ticks(3);
        chk("idle_adclk_hold", adclk, 0);

        for (int i = 0; i < 10; i++) begin
            chk($sformatf("drain_data_%0d", i),  m_data,  drain_tbl[i].exp_data);
            chk($sformatf("drain_level_%0d", i), level,   drain_tbl[i].exp_level);
            chk($sformatf("drain_valid_%0d", i), m_valid, 1);
            m_ready = drain_tbl[i].rdy;
            tick();
        end
        m_ready = 1'b0;
        chk("drained_level", level,   0);
        chk("drained_valid", m_valid, 0);
        chk("drained_ovf",   overflow, 0);

        // re-enable flushes again; then reset asynchronously with three samples buffered
        base   = ramp;
        enable = 1'b1;
        ticks(25);
        chk("reen_flush_level", level, 0);
        ticks(9);
        chk("reen_level", level, 3);
        chk("reen_head",  m_data, (base + 5) & 8'hff);
        chk("reen_adclk_high", adclk, 1);
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_adclk", adclk,   0);
        chk("async_level", level,   0);
        chk("async_valid", m_valid, 0);
        chk("async_data",  m_data,  0);
        #10;
        rst_n      = 1'b1;
        adclk_prev = 1'b0;
        base       = ramp;
        ticks(25);
        chk("post_rst_flush_level", level, 0);
        tick();
        chk("post_rst_level", level,   1);
        chk("post_rst_head",  m_data,  (base + 5) & 8'hff);
        chk("post_rst_ovf",   overflow, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
